// File: rtl/led_mode_sequencer.sv
// Switch/button front end and LED pattern generator (PASS, BLINK, CHASE, COUNT).
// Define LED_SEQ_COUNT_EN to build COUNT mode; otherwise the mode cycle is PASS->BLINK->CHASE.
module led_mode_sequencer #(
    parameter int N          = 4,
    parameter int TICK_DIV   = 4,
    parameter int DEB_CYCLES = 3
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [N-1:0] i_switch,
    input  logic         i_button,
    output logic [N-1:0] o_LED,
    output logic [1:0]   o_mode,
    output logic         o_tick
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_BLINK = 2'd1,
        MODE_CHASE = 2'd2,
        MODE_COUNT = 2'd3
    } mode_t;

    logic [N-1:0]  r_sw_meta, r_sw_s;
    logic          r_btn_meta, r_btn_s;
    logic [DW-1:0] r_deb_cnt;
    logic          r_btn_db, r_btn_db_d;
    logic          w_btn_rise;
    mode_t         r_mode, w_mode_next;
    logic          w_mode_chg;
    logic [PW-1:0] r_presc;
    logic          w_tick;
    logic          r_phase;
    logic [N-1:0]  r_chase;
    logic [N-1:0]  w_count_led;
    logic [N-1:0]  r_led;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sw_meta  <= '0;
            r_sw_s     <= '0;
            r_btn_meta <= 1'b0;
            r_btn_s    <= 1'b0;
        end else begin
            r_sw_meta  <= i_switch;
            r_sw_s     <= r_sw_meta;
            r_btn_meta <= i_button;
            r_btn_s    <= r_btn_meta;
        end
    end

    // A change is accepted only after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_deb_cnt  <= '0;
            r_btn_db   <= 1'b0;
            r_btn_db_d <= 1'b0;
        end else begin
            r_btn_db_d <= r_btn_db;
            if (r_btn_s == r_btn_db) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == DEB_LAST) begin
                r_btn_db  <= r_btn_s;
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + DW'(1);
            end
        end
    end

    assign w_btn_rise = r_btn_db & ~r_btn_db_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_mode <= MODE_PASS;
        else          r_mode <= w_mode_next;
    end

    // NOTE: default assignment first keeps this combinational block latch-free.
    always_comb begin
        w_mode_next = r_mode;
        if (w_btn_rise) begin
            case (r_mode)
                MODE_PASS:  w_mode_next = MODE_BLINK;
                MODE_BLINK: w_mode_next = MODE_CHASE;
`ifdef LED_SEQ_COUNT_EN
                MODE_CHASE: w_mode_next = MODE_COUNT;
`else
                MODE_CHASE: w_mode_next = MODE_PASS;
`endif
                default:    w_mode_next = MODE_PASS;
            endcase
        end
    end

    always_comb begin
        o_mode     = r_mode;
        w_mode_chg = (w_mode_next != r_mode);
    end

    assign w_tick = (r_presc == PRESC_LAST);
    assign o_tick = w_tick;

    // A mode change reinitializes the pattern even when it coincides with a tick.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_presc <= '0;
            r_phase <= 1'b1;
            r_chase <= N'(1);
        end else if (w_mode_chg) begin
            r_presc <= '0;
            r_phase <= 1'b1;
            r_chase <= N'(1);
        end else if (w_tick) begin
            r_presc <= '0;
            r_phase <= ~r_phase;
            r_chase <= {r_chase[N-2:0], r_chase[N-1]};
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

`ifdef LED_SEQ_COUNT_EN
    logic [N-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)        r_count <= '0;
        else if (w_mode_chg) r_count <= '0;
        else if (w_tick)     r_count <= r_count + N'(1);
    end

    assign w_count_led = r_count;
`else
    assign w_count_led = '0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_led <= '0;
        end else begin
            case (r_mode)
                MODE_PASS:  r_led <= r_sw_s;
                MODE_BLINK: r_led <= r_sw_s & {N{r_phase}};
                MODE_CHASE: r_led <= r_chase;
                default:    r_led <= w_count_led;
            endcase
        end
    end

    assign o_LED = r_led;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Self-checking bench for led_mode_sequencer: directed scenarios plus randomized
// switch/button traffic compared against a cycle-count based reference model.
`timescale 1ns/1ps
module tb_led_mode_sequencer;
    localparam int N          = 4;
    localparam int TICK_DIV   = 4;
    localparam int DEB_CYCLES = 3;
`ifdef LED_SEQ_COUNT_EN
    localparam int NMODES = 4;
`else
    localparam int NMODES = 3;
`endif

    logic         i_clk    = 1'b0;
    logic         i_rst_n  = 1'b1;
    logic [N-1:0] i_switch = '0;
    logic         i_button = 1'b0;
    logic [N-1:0] o_LED;
    logic [1:0]   o_mode;
    logic         o_tick;

    int checks = 0;
    int errors = 0;

    led_mode_sequencer #(.N(N), .TICK_DIV(TICK_DIV), .DEB_CYCLES(DEB_CYCLES)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_switch (i_switch),
        .i_button (i_button),
        .o_LED    (o_LED),
        .o_mode   (o_mode),
        .o_tick   (o_tick)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: patterns derived from the number of edges since the last mode change.
    int           m_mode;
    int           m_since;
    logic [N-1:0] m_led, m_sw_s1, m_sw_s;
    logic         m_btn_s1, m_btn_s, m_db, m_db_prev;
    logic         btn_hist[$];

    function automatic logic [N-1:0] led_of(int mode, int since, logic [N-1:0] sw);
        int ticks;
        logic [N-1:0] one;
        ticks = since / TICK_DIV;
        one   = 1;
        case (mode)
            0:       return sw;
            1:       return (ticks % 2 == 0) ? sw : '0;
            2:       return one << (ticks % N);
            default: return N'(ticks % (1 << N));
        endcase
    endfunction

    function automatic logic exp_tick();
        return (m_since % TICK_DIV) == (TICK_DIV - 1);
    endfunction

    function automatic logic [1:0] exp_mode();
        return 2'(m_mode);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_since = 0; m_led = '0;
        m_sw_s1 = '0; m_sw_s = '0;
        m_btn_s1 = 1'b0; m_btn_s = 1'b0; m_db = 1'b0; m_db_prev = 1'b0;
        btn_hist.delete();
        btn_hist.push_back(1'b0);
    endtask

    task automatic model_edge(input logic [N-1:0] sw, input logic btn);
        logic flip;
        m_led = led_of(m_mode, m_since, m_sw_s);
        flip  = 1'b0;
        if (btn_hist.size() >= DEB_CYCLES) begin
            flip = 1'b1;
            for (int i = 1; i <= DEB_CYCLES; i++)
                if (btn_hist[btn_hist.size() - i] == m_db) flip = 1'b0;
        end
        if (m_db && !m_db_prev) begin
            m_mode  = (m_mode + 1) % NMODES;
            m_since = 0;
        end else begin
            m_since++;
        end
        m_db_prev = m_db;
        if (flip) m_db = ~m_db;
        m_sw_s   = m_sw_s1;  m_sw_s1  = sw;
        m_btn_s  = m_btn_s1; m_btn_s1 = btn;
        btn_hist.push_back(m_btn_s);
        if (btn_hist.size() > 64) void'(btn_hist.pop_front());
    endtask

    task automatic step(input logic [N-1:0] sw, input logic btn);
        @(negedge i_clk);
        i_switch = sw;
        i_button = btn;
        @(posedge i_clk);
        model_edge(sw, btn);
        #1;
    endtask

    task automatic press_button(input string name);
        for (int i = 0; i < 2 * DEB_CYCLES + 7; i++) begin
            step(i_switch, i < DEB_CYCLES + 3);
            checks++;
            if ({o_LED, o_mode, o_tick} !== {m_led, exp_mode(), exp_tick()}) begin
                errors++;
                $display("FAIL %s cyc%0d: got led=%b mode=%0d tick=%b, want led=%b mode=%0d tick=%b",
                         name, i, o_LED, o_mode, o_tick, m_led, exp_mode(), exp_tick());
            end
        end
    endtask

    task automatic test_reset();
        #2 i_rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({o_LED, o_mode, o_tick} !== {4'b0000, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_async: got led=%b mode=%0d tick=%b, want 0000/0/0", o_LED, o_mode, o_tick);
        end
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        model_edge(i_switch, i_button);
        #1;
        checks++;
        if ({o_LED, o_mode, o_tick} !== {m_led, exp_mode(), exp_tick()}) begin
            errors++;
            $display("FAIL reset_release: got led=%b mode=%0d tick=%b, want led=%b mode=%0d tick=%b",
                     o_LED, o_mode, o_tick, m_led, exp_mode(), exp_tick());
        end
    endtask

    task automatic test_pass();
        logic [N-1:0] pats [2];
        pats[0] = 4'b0100;
        pats[1] = 4'b1010;
        foreach (pats[p]) begin
            for (int i = 1; i <= 5; i++) begin
                step(pats[p], 1'b0);
                checks++;
                if ({o_LED, o_mode, o_tick} !== {m_led, exp_mode(), exp_tick()}) begin
                    errors++;
                    $display("FAIL pass_%b cyc%0d: got led=%b mode=%0d tick=%b, want led=%b mode=%0d tick=%b",
                             pats[p], i, o_LED, o_mode, o_tick, m_led, exp_mode(), exp_tick());
                end
                if (i == 3) begin
                    checks++;
                    if (o_LED !== pats[p]) begin
                        errors++;
                        $display("FAIL pass_latency: got led=%b, want %b", o_LED, pats[p]);
                    end
                end
            end
        end
    endtask

    task automatic test_debounce();
        int rise_at;
        rise_at = -1;
        for (int w = 1; w <= 2; w++) begin
            for (int i = 0; i < w + 8; i++) begin
                step(i_switch, i < w);
                checks++;
                if ({o_LED, o_mode, o_tick} !== {m_led, exp_mode(), exp_tick()} || o_mode !== 2'd0) begin
                    errors++;
                    $display("FAIL bounce_%0d cyc%0d: got led=%b mode=%0d tick=%b, want led=%b mode=0 tick=%b",
                             w, i, o_LED, o_mode, o_tick, m_led, exp_tick());
                end
            end
        end
        for (int i = 1; i <= 18; i++) begin
            step(i_switch, i <= 10);
            if (o_mode == 2'd1 && rise_at < 0) rise_at = i;
            checks++;
            if ({o_LED, o_mode, o_tick} !== {m_led, exp_mode(), exp_tick()}) begin
                errors++;
                $display("FAIL hold cyc%0d: got led=%b mode=%0d tick=%b, want led=%b mode=%0d tick=%b",
                         i, o_LED, o_mode, o_tick, m_led, exp_mode(), exp_tick());
            end
        end
        // Step i drives the level sampled at edge k+i-1, so the mode must show at step DEB_CYCLES+3.
        checks++;
        if (rise_at !== DEB_CYCLES + 3 || o_mode !== 2'd1) begin
            errors++;
            $display("FAIL hold_latency: got first-step=%0d final mode=%0d, want step %0d mode 1",
                     rise_at, o_mode, DEB_CYCLES + 3);
        end
    endtask

    task automatic test_blink();
        int ticks_seen;
        ticks_seen = 0;
        for (int i = 0; i < 32; i++) begin
            step(4'b1010, 1'b0);
            if (o_tick) ticks_seen++;
            checks++;
            if ({o_LED, o_mode, o_tick} !== {m_led, exp_mode(), exp_tick()}) begin
                errors++;
                $display("FAIL blink cyc%0d: got led=%b mode=%0d tick=%b, want led=%b mode=%0d tick=%b",
                         i, o_LED, o_mode, o_tick, m_led, exp_mode(), exp_tick());
            end
        end
        checks++;
        if (ticks_seen !== 32 / TICK_DIV) begin
            errors++;
            $display("FAIL blink_tick_rate: got %0d ticks, want %0d", ticks_seen, 32 / TICK_DIV);
        end
    endtask

    task automatic test_chase();
        logic [N-1:0] prev;
        int changes;
        press_button("chase_press");
        checks++;
        if (o_mode !== 2'd2) begin
            errors++;
            $display("FAIL chase_mode: got %0d, want 2", o_mode);
        end
        prev = o_LED;
        changes = 0;
        for (int i = 0; i < 24; i++) begin
            step(i_switch, 1'b0);
            checks++;
            if ({o_LED, o_mode, o_tick} !== {m_led, exp_mode(), exp_tick()}) begin
                errors++;
                $display("FAIL chase cyc%0d: got led=%b mode=%0d tick=%b, want led=%b mode=%0d tick=%b",
                         i, o_LED, o_mode, o_tick, m_led, exp_mode(), exp_tick());
            end
            if (o_LED !== prev) begin
                changes++;
                checks++;
                if (o_LED !== {prev[N-2:0], prev[N-1]}) begin
                    errors++;
                    $display("FAIL chase_rotate: got %b after %b", o_LED, prev);
                end
                prev = o_LED;
            end
        end
        checks++;
        if (changes !== 24 / TICK_DIV) begin
            errors++;
            $display("FAIL chase_rate: got %0d steps, want %0d", changes, 24 / TICK_DIV);
        end
    endtask

`ifdef LED_SEQ_COUNT_EN
    task automatic test_count();
        logic [N-1:0] prev;
        bit wrapped;
        press_button("count_press");
        checks++;
        if (o_mode !== 2'd3) begin
            errors++;
            $display("FAIL count_mode: got %0d, want 3", o_mode);
        end
        prev = o_LED;
        wrapped = 1'b0;
        for (int i = 0; i < 16 * TICK_DIV + 8; i++) begin
            step(4'b0110, 1'b0);
            checks++;
            if ({o_LED, o_mode, o_tick} !== {m_led, exp_mode(), exp_tick()}) begin
                errors++;
                $display("FAIL count cyc%0d: got led=%b mode=%0d tick=%b, want led=%b mode=%0d tick=%b",
                         i, o_LED, o_mode, o_tick, m_led, exp_mode(), exp_tick());
            end
            if (o_LED !== prev) begin
                if (prev == 4'b1111 && o_LED == 4'b0000) wrapped = 1'b1;
                checks++;
                if (o_LED !== prev + 4'd1) begin
                    errors++;
                    $display("FAIL count_step: got %b after %b", o_LED, prev);
                end
                prev = o_LED;
            end
        end
        checks++;
        if (!wrapped) begin
            errors++;
            $display("FAIL count_wrap: got no 1111->0000 transition, want one");
        end
        press_button("count_exit");
        checks++;
        if (o_mode !== 2'd0 || o_LED !== 4'b0110) begin
            errors++;
            $display("FAIL count_exit_pass: got mode=%0d led=%b, want mode=0 led=0110", o_mode, o_LED);
        end
    endtask
`else
    task automatic test_count();
        press_button("chase_exit");
        checks++;
        if (o_mode !== 2'd0) begin
            errors++;
            $display("FAIL chase_exit_mode: got %0d, want 0", o_mode);
        end
    endtask
`endif

    task automatic test_mid_reset();
        int budget;
        press_button("mid_press1");
        press_button("mid_press2");
        budget = 0;
        while (!(m_mode == 2 && m_led == 4'b0100) && budget < 60) begin
            step(4'b0011, 1'b0);
            budget++;
        end
        checks++;
        if (o_LED !== 4'b0100 || o_mode !== 2'd2) begin
            errors++;
            $display("FAIL mid_chase_reach: got led=%b mode=%0d after %0d cycles, want 0100/2",
                     o_LED, o_mode, budget);
        end
        i_rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({o_LED, o_mode, o_tick} !== {4'b0000, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset_async: got led=%b mode=%0d tick=%b, want 0000/0/0", o_LED, o_mode, o_tick);
        end
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        model_edge(i_switch, i_button);
        #1;
        for (int i = 0; i < 6; i++) begin
            step(4'b1001, 1'b0);
            checks++;
            if ({o_LED, o_mode, o_tick} !== {m_led, exp_mode(), exp_tick()}) begin
                errors++;
                $display("FAIL mid_reset_pass cyc%0d: got led=%b mode=%0d tick=%b, want led=%b mode=%0d tick=%b",
                         i, o_LED, o_mode, o_tick, m_led, exp_mode(), exp_tick());
            end
        end
    endtask

    task automatic test_random();
        int hold;
        logic btn;
        hold = 0;
        btn  = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (hold == 0) begin
                btn  = ~btn;
                hold = $urandom_range(1, 12);
            end
            hold--;
            step(N'($urandom), btn);
            checks++;
            if ({o_LED, o_mode, o_tick} !== {m_led, exp_mode(), exp_tick()}) begin
                errors++;
                $display("FAIL random cyc%0d: got led=%b mode=%0d tick=%b, want led=%b mode=%0d tick=%b",
                         i, o_LED, o_mode, o_tick, m_led, exp_mode(), exp_tick());
            end
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_debounce();
        test_blink();
        test_chase();
        test_count();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
